// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter family (up- and down-counters).
//   state_e : control FSM encoding shared by all counter flavours.
//   clamp() : saturates a load value to the largest legal count.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Operand width of clamp(). Callers zero-extend their WIDTH-bit values
  // and truncate the result back; the compare is value-preserving, so no
  // count bit wider than WIDTH ever reaches the counter itself.
  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] v,
                                               input logic [CLAMP_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/mod_down_counter.sv
// Loadable modulo-MODULUS down-counter with borrow-out, for ripple cascade.
//   clk     : rising-edge clock
//   mr      : synchronous active-low master reset
//   en      : count enable / borrow-in from the less significant stage
//   ld      : synchronous parallel load (beats en)
//   d       : load value, saturated to MODULUS-1
//   oneshot : 1 = stop at zero and flag done, 0 = wrap to MODULUS-1
//   q       : current count
//   bo      : borrow-out, combinational: en & q==0 & RUN
//   done    : registered, high while parked at zero (HOLD)
//   busy    : high in RUN
// Parameters: WIDTH (<= 32), MODULUS in 2..2**WIDTH.
module mod_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             bo,
  output logic             done,
  output logic             busy
);

  // MODULUS may equal 2**WIDTH, which doesn't fit in WIDTH bits; the
  // terminal value MODULUS-1 always does, so everything works against it.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] ld_val;
  logic             cnt_zero;

  assign ld_val   = WIDTH'(clamp(CLAMP_W'(d), CLAMP_W'(MAX_CNT)));
  assign cnt_zero = (cnt_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!mr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state. Load wins over count in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (ld) begin
      cnt_d   = ld_val;
      state_d = RUN;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;  // en ignored until the first load
        RUN: begin
          if (en) begin
            if (!cnt_zero) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (!oneshot) begin
              cnt_d = MAX_CNT;
            end else begin
              // oneshot only matters here, at the zero decision edge
              state_d = HOLD;
              done_d  = 1'b1;
            end
          end
        end
        HOLD: ;  // parked at zero; only ld leaves
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Outputs. bo is zero-latency from en so a cascaded stage decrements on
  // the same edge that this stage wraps or terminates.
  always_comb begin
    busy = (state_q == RUN);
    bo   = en && cnt_zero && (state_q == RUN);
    q    = cnt_q;
    done = done_q;
  end

endmodule
